// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED chase controller.
// Holds the FSM state encoding, speed range and pattern helpers.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [1:0] SPEED_MAX    = 2'd2;
    localparam logic [3:0] PATTERN_INIT = 4'b0001;

    // dir 0 rotates toward bit 3, dir 1 toward bit 0; both wrap.
    function automatic logic [3:0] rotate_pattern(input logic [3:0] pattern, input logic dir);
        return dir ? {pattern[0], pattern[3:1]} : {pattern[2:0], pattern[3]};
    endfunction

    function automatic logic [1:0] next_speed(input logic [1:0] speed);
        return (speed == SPEED_MAX) ? 2'd0 : speed + 2'd1;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Synchronises one raw switch, debounces it and emits a one-cycle pulse
// in the cycle after the debounced level falls (switch released).
module debounce_filter #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic switch_raw,
    output logic release_evt
);

    localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            level      <= 1'b0;
            level_d    <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_1  <= switch_raw;
            sync_2  <= sync_1;
            level_d <= level;
            // Flip on the LIMIT-th consecutive disagreeing sample.
            if (sync_2 != level) begin
                if (stable_cnt == CNT_LAST) begin
                    level      <= sync_2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    assign release_evt = level_d & ~level;

endmodule

// File: rtl/led_chase_controller.sv
// Board controller: four debounced switch release events drive an FSM that
// starts, pauses, reverses, re-speeds and stops a one-hot LED chase.
module led_chase_controller
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int STEP_TICKS     = 6250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    input  logic i_Switch_3,
    input  logic i_Switch_4,
    output logic o_LED_1,
    output logic o_LED_2,
    output logic o_LED_3,
    output logic o_LED_4
);

    localparam int STEP_W = $clog2(STEP_TICKS);
    localparam logic [STEP_W-1:0] STEP_LAST_0 = STEP_W'(STEP_TICKS - 1);
    localparam logic [STEP_W-1:0] STEP_LAST_1 = STEP_W'((STEP_TICKS >> 1) - 1);
    localparam logic [STEP_W-1:0] STEP_LAST_2 = STEP_W'((STEP_TICKS >> 2) - 1);

    logic [3:0] switch_raw;
    logic [3:0] release_evt;

    assign switch_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    for (genvar g = 0; g < 4; g++) begin : g_switch
        debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_debounce (
            .i_Clk       (i_Clk),
            .i_Rst_L     (i_Rst_L),
            .switch_raw  (switch_raw[g]),
            .release_evt (release_evt[g])
        );
    end

    state_t            state,      state_nxt;
    logic [3:0]        pattern,    pattern_nxt;
    logic              dir,        dir_nxt;
    logic [1:0]        speed,      speed_nxt;
    logic [STEP_W-1:0] step_cnt,   step_cnt_nxt;
    logic [STEP_W-1:0] step_last;
    logic [3:0]        led_q;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state    <= ST_IDLE;
            pattern  <= PATTERN_INIT;
            dir      <= 1'b0;
            speed    <= 2'd0;
            step_cnt <= '0;
            led_q    <= 4'b0000;
        end else begin
            state    <= state_nxt;
            pattern  <= pattern_nxt;
            dir      <= dir_nxt;
            speed    <= speed_nxt;
            step_cnt <= step_cnt_nxt;
            led_q    <= (state != ST_IDLE) ? pattern : 4'b0000;
        end
    end

    always_comb begin
        case (speed)
            2'd1:    step_last = STEP_LAST_1;
            2'd2:    step_last = STEP_LAST_2;
            default: step_last = STEP_LAST_0;
        endcase
    end

    // Stepping uses the current dir, so a reversal only shows at the next step.
    always_comb begin
        state_nxt    = state;
        pattern_nxt  = pattern;
        dir_nxt      = dir;
        speed_nxt    = speed;
        step_cnt_nxt = step_cnt;

        if (release_evt[3]) begin
            state_nxt    = ST_IDLE;
            pattern_nxt  = PATTERN_INIT;
            dir_nxt      = 1'b0;
            step_cnt_nxt = '0;
        end else begin
            if (state == ST_RUN) begin
                if (step_cnt == step_last) begin
                    step_cnt_nxt = '0;
                    pattern_nxt  = rotate_pattern(pattern, dir);
                end else begin
                    step_cnt_nxt = step_cnt + 1'b1;
                end
            end

            if (release_evt[0]) begin
                case (state)
                    ST_IDLE: begin
                        state_nxt    = ST_RUN;
                        step_cnt_nxt = '0;
                    end
                    ST_RUN:   state_nxt = ST_PAUSE;
                    ST_PAUSE: state_nxt = ST_RUN;
                    default:  state_nxt = ST_IDLE;
                endcase
            end

            if (release_evt[1]) begin
                dir_nxt = ~dir;
            end

            if (release_evt[2]) begin
                speed_nxt    = next_speed(speed);
                step_cnt_nxt = '0;
            end
        end
    end

    assign o_LED_1 = led_q[0];
    assign o_LED_2 = led_q[1];
    assign o_LED_3 = led_q[2];
    assign o_LED_4 = led_q[3];

endmodule

// File: tb/tb_led_chase_controller.sv
// Randomised self-checking bench for led_chase_controller against a
// cycle-level behavioural model built from the switch/chase rules.
module tb_led_chase_controller;

    localparam int DEB  = 4;
    localparam int STEP = 8;

    logic       i_Clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw    = 4'b0000;
    logic       o_LED_1, o_LED_2, o_LED_3, o_LED_4;

    int checks = 0;
    int errors = 0;

    always #5 i_Clk = ~i_Clk;

    led_chase_controller #(.DEBOUNCE_LIMIT(DEB), .STEP_TICKS(STEP)) dut (
        .i_Clk      (i_Clk),
        .i_Rst_L    (rst_n),
        .i_Switch_1 (sw[0]),
        .i_Switch_2 (sw[1]),
        .i_Switch_3 (sw[2]),
        .i_Switch_4 (sw[3]),
        .o_LED_1    (o_LED_1),
        .o_LED_2    (o_LED_2),
        .o_LED_3    (o_LED_3),
        .o_LED_4    (o_LED_4)
    );

    // Model: mode 0 idle, 1 running, 2 paused; lit LED position 0..3.
    int         m_mode, m_pos, m_speed, m_ticks;
    bit         m_up;
    logic [3:0] m_led;
    int         m_d1[4], m_d2[4], m_lvl[4], m_run[4];
    bit         m_ev[4];

    function automatic logic [3:0] leds();
        return {o_LED_4, o_LED_3, o_LED_2, o_LED_1};
    endfunction

    task automatic model_edge();
        int samp;
        int period;
        if (!rst_n) begin
            m_mode = 0; m_pos = 0; m_up = 1; m_speed = 0; m_ticks = 0; m_led = 4'b0000;
            for (int i = 0; i < 4; i++) begin
                m_d1[i] = 0; m_d2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_ev[i] = 0;
            end
        end else begin
            m_led = (m_mode == 0) ? 4'b0000 : 4'(1 << m_pos);
            if (m_ev[3]) begin
                m_mode = 0; m_pos = 0; m_up = 1; m_ticks = 0;
            end else begin
                if (m_mode == 1) begin
                    period = STEP / (2 ** m_speed);
                    m_ticks++;
                    if (m_ticks == period) begin
                        m_ticks = 0;
                        m_pos = m_up ? (m_pos + 1) % 4 : (m_pos + 3) % 4;
                    end
                end
                if (m_ev[0]) begin
                    if (m_mode == 0) begin m_mode = 1; m_ticks = 0; end
                    else if (m_mode == 1) m_mode = 2;
                    else m_mode = 1;
                end
                if (m_ev[1]) m_up = !m_up;
                if (m_ev[2]) begin m_speed = (m_speed + 1) % 3; m_ticks = 0; end
            end
            for (int i = 0; i < 4; i++) begin
                samp = m_d2[i];
                m_d2[i] = m_d1[i];
                m_d1[i] = int'(sw[i]);
                m_ev[i] = 0;
                if (samp != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_ev[i] = (m_lvl[i] == 1);
                        m_lvl[i] = samp;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        model_edge();
        #1;
    endtask

    task automatic press(input logic [3:0] mask, input int n);
        sw = sw | mask;
        repeat (n) tick();
        sw = sw & ~mask;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw = 4'b0000;
        repeat (3) begin
            tick();
            checks++;
            if (leds() !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold: leds=%b expected=0000 t=%0t", leds(), $time);
            end
        end
        rst_n = 1'b1;
        repeat (12) begin
            tick();
            checks++;
            if (leds() !== 4'b0000 || leds() !== m_led) begin
                errors++;
                $display("FAIL reset_idle: leds=%b expected=0000 t=%0t", leds(), $time);
            end
        end
    endtask

    task automatic test_start();
        press(4'b0001, 10 + $urandom_range(0, 5));
        for (int k = 1; k <= 40; k++) begin
            tick();
            checks++;
            if (leds() !== m_led) begin
                errors++;
                $display("FAIL start_chase: leds=%b expected=%b t=%0t", leds(), m_led, $time);
            end
            if (k == 10 || k == 16) begin
                checks++;
                if (leds() !== ((k == 10) ? 4'b0001 : 4'b0010)) begin
                    errors++;
                    $display("FAIL start_fixed: leds=%b expected=%b k=%0d", leds(),
                             (k == 10) ? 4'b0001 : 4'b0010, k);
                end
            end
        end
    endtask

    task automatic test_glitch();
        repeat (5) begin
            sw[0] = 1'b1;
            repeat (3) tick();
            sw[0] = 1'b0;
            tick();
        end
        repeat (30) begin
            tick();
            checks++;
            if (leds() !== m_led || m_mode != 1) begin
                errors++;
                $display("FAIL glitch: leds=%b expected=%b mode=%0d", leds(), m_led, m_mode);
            end
        end
    endtask

    task automatic test_reverse_speed();
        press(4'b0010, 6 + $urandom_range(0, 6));
        repeat (30) begin
            tick();
            checks++;
            if (leds() !== m_led) begin
                errors++;
                $display("FAIL reverse: leds=%b expected=%b t=%0t", leds(), m_led, $time);
            end
        end
        for (int s = 0; s < 3; s++) begin
            press(4'b0100, 6 + $urandom_range(0, 6));
            repeat (30) begin
                tick();
                checks++;
                if (leds() !== m_led) begin
                    errors++;
                    $display("FAIL speed%0d: leds=%b expected=%b t=%0t", s, leds(), m_led, $time);
                end
            end
        end
    endtask

    task automatic test_pause();
        logic [3:0] held;
        press(4'b0001, 6 + $urandom_range(0, 6));
        repeat (10) tick();
        held = m_led;
        repeat (50) begin
            tick();
            checks++;
            if (leds() !== held || leds() !== m_led) begin
                errors++;
                $display("FAIL pause_hold: leds=%b expected=%b t=%0t", leds(), held, $time);
            end
        end
        press(4'b0001, 6 + $urandom_range(0, 6));
        repeat (40) begin
            tick();
            checks++;
            if (leds() !== m_led) begin
                errors++;
                $display("FAIL resume: leds=%b expected=%b t=%0t", leds(), m_led, $time);
            end
        end
    endtask

    task automatic test_stop_and_reset();
        press(4'b1001, 8);
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if (leds() !== m_led || (k >= 10 && leds() !== 4'b0000)) begin
                errors++;
                $display("FAIL stop_combo: leds=%b expected=%b k=%0d", leds(), m_led, k);
            end
        end
        press(4'b0001, 8);
        repeat (20) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (leds() !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset: leds=%b expected=0000 t=%0t", leds(), $time);
        end
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            checks++;
            if (leds() !== 4'b0000 || leds() !== m_led) begin
                errors++;
                $display("FAIL post_reset: leds=%b expected=0000 t=%0t", leds(), $time);
            end
        end
    endtask

    task automatic test_random();
        int hold[4];
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    sw[i] = (i == 3) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 12);
                end else begin
                    hold[i]--;
                end
            end
            rst_n = ($urandom_range(0, 999) != 0);
            tick();
            checks++;
            if (leds() !== m_led) begin
                errors++;
                $display("FAIL random: leds=%b expected=%b cycle=%0d", leds(), m_led, k);
            end
        end
        sw = 4'b0000;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_start();
        test_glitch();
        test_reverse_speed();
        test_pause();
        test_stop_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
